// File: rtl/psram_pkg.sv
// Shared types and defaults for the PSRAM port arbiter: FSM states, timing defaults
// and the captured request record.
package psram_pkg;

  localparam int T_ACC_DEF = 4;
  localparam int T_REC_DEF = 1;
  localparam int AW_DEF    = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_MCU,
    ST_REC
  } state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic              we;
    logic [7:0]        wdat;
  } mem_req_t;

endpackage

// File: rtl/psram_req_latch.sv
// CPU port front end: rising-edge detection on cpu_req plus a shadow copy of the request.
// A newer edge overwrites the shadow while the previous request is still pending.
module psram_req_latch
  import psram_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdat,
  input  logic          pend_clr,
  output logic          cpu_pend,
  output mem_req_t      cpu_shadow
);

  logic     req_q;
  logic     pend_q, pend_d;
  mem_req_t shadow_q, shadow_d;
  logic     rise;

  assign rise = cpu_req & ~req_q;

  always_comb begin
    pend_d   = pend_q;
    shadow_d = shadow_q;
    if (rise) begin
      pend_d        = 1'b1;
      shadow_d.addr = AW_DEF'(cpu_addr);
      shadow_d.we   = cpu_we;
      shadow_d.wdat = cpu_wdat;
    end else if (pend_clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      req_q    <= cpu_req;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
    end
  end

  assign cpu_pend   = pend_q;
  assign cpu_shadow = shadow_q;

endmodule

// File: rtl/psram_port_arb.sv
// Two-port (CPU first, then MCU) byte-wide PSRAM access sequencer with ce/oe/we timing.
// Optional build macro PSRAM_MCU_AUTOINC_EN adds an auto-incrementing MCU address pointer.
module psram_port_arb
  import psram_pkg::*;
#(
  parameter int T_ACC = T_ACC_DEF,
  parameter int T_REC = T_REC_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdat,
  output logic [7:0]    cpu_rdat,
  output logic          cpu_busy,
  input  logic          mcu_req,
  input  logic [AW-1:0] mcu_addr,
  input  logic          mcu_we,
  input  logic [7:0]    mcu_wdat,
`ifdef PSRAM_MCU_AUTOINC_EN
  input  logic          mcu_addr_ld,
`endif
  output logic [7:0]    mcu_rdat,
  output logic          mcu_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ce,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [7:0]    mem_dati,
  input  logic [7:0]    mem_dato
);

  localparam int CMAX = (T_ACC > T_REC) ? T_ACC : T_REC;
  localparam int CW   = $clog2(CMAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_dati_q, mem_dati_d;
  logic          we_q, we_d;
  logic [7:0]    cpu_rdat_q, cpu_rdat_d;
  logic [7:0]    mcu_rdat_q, mcu_rdat_d;
  logic          mcu_ack_q, mcu_ack_d;
  logic          pend_clr, cpu_pend, access;
  mem_req_t      cpu_shadow, mcu_r;
  logic [AW-1:0] mcu_eff_addr;

  psram_req_latch #(.AW(AW)) u_req_latch (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdat   (cpu_wdat),
    .pend_clr   (pend_clr),
    .cpu_pend   (cpu_pend),
    .cpu_shadow (cpu_shadow)
  );

`ifdef PSRAM_MCU_AUTOINC_EN
  logic          mcu_req_q, mcu_ld;
  logic [AW-1:0] mcu_ptr_q, mcu_ptr_d;

  // A fresh request (or explicit reload) bypasses the pointer so it takes effect immediately.
  assign mcu_ld       = (mcu_req & ~mcu_req_q) | mcu_addr_ld;
  assign mcu_eff_addr = mcu_ld ? mcu_addr : mcu_ptr_q;

  always_comb begin
    mcu_ptr_d = mcu_ptr_q;
    if (mcu_ld)         mcu_ptr_d = mcu_addr;
    else if (mcu_ack_d) mcu_ptr_d = mcu_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcu_req_q <= 1'b0;
      mcu_ptr_q <= '0;
    end else begin
      mcu_req_q <= mcu_req;
      mcu_ptr_q <= mcu_ptr_d;
    end
  end
`else
  assign mcu_eff_addr = mcu_addr;
`endif

  always_comb begin
    mcu_r      = '0;
    mcu_r.addr = AW_DEF'(mcu_eff_addr);
    mcu_r.we   = mcu_we;
    mcu_r.wdat = mcu_wdat;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_dati_d = mem_dati_q;
    we_d       = we_q;
    cpu_rdat_d = cpu_rdat_q;
    mcu_rdat_d = mcu_rdat_q;
    mcu_ack_d  = 1'b0;
    pend_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_pend) begin
          state_d    = ST_CPU;
          pend_clr   = 1'b1;
          cnt_d      = CW'(T_ACC - 1);
          mem_addr_d = cpu_shadow.addr[AW-1:0];
          mem_dati_d = cpu_shadow.wdat;
          we_d       = cpu_shadow.we;
        end else if (mcu_req) begin
          state_d    = ST_MCU;
          cnt_d      = CW'(T_ACC - 1);
          mem_addr_d = mcu_r.addr[AW-1:0];
          mem_dati_d = mcu_r.wdat;
          we_d       = mcu_r.we;
        end
      end
      ST_CPU, ST_MCU: begin
        if (cnt_q == '0) begin
          state_d = ST_REC;
          cnt_d   = CW'(T_REC - 1);
          if (state_q == ST_CPU) begin
            if (!we_q) cpu_rdat_d = mem_dato;
          end else if (mcu_req) begin
            // An abandoned MCU request still finishes its access but is not acknowledged.
            mcu_ack_d = 1'b1;
            if (!we_q) mcu_rdat_d = mem_dato;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_REC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_dati_q <= '0;
      we_q       <= 1'b0;
      cpu_rdat_q <= '0;
      mcu_rdat_q <= '0;
      mcu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_dati_q <= mem_dati_d;
      we_q       <= we_d;
      cpu_rdat_q <= cpu_rdat_d;
      mcu_rdat_q <= mcu_rdat_d;
      mcu_ack_q  <= mcu_ack_d;
    end
  end

  // Strobes decode straight from the state flop so reset drops them in the same cycle.
  assign access   = (state_q == ST_CPU) || (state_q == ST_MCU);
  assign mem_ce   = access;
  assign mem_we   = access & we_q;
  assign mem_oe   = ~(access & we_q);
  assign mem_addr = mem_addr_q;
  assign mem_dati = mem_dati_q;
  assign cpu_rdat = cpu_rdat_q;
  assign mcu_rdat = mcu_rdat_q;
  assign mcu_ack  = mcu_ack_q;
  assign cpu_busy = cpu_pend | (state_q == ST_CPU);

endmodule

// File: tb/tb_psram_port_arb.sv
// Directed self-checking bench for psram_port_arb; covers the auto-increment feature
// when PSRAM_MCU_AUTOINC_EN is defined.
module tb_psram_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, mcu_req, mcu_we, mcu_addr_ld;
  logic [23:0] cpu_addr, mcu_addr, mem_addr;
  logic [7:0]  cpu_wdat, mcu_wdat, cpu_rdat, mcu_rdat, mem_dati, mem_dato;
  logic        cpu_busy, mcu_ack, mem_ce, mem_oe, mem_we;

  int total = 0;
  int bad   = 0;

  psram_port_arb dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_wdat    (cpu_wdat),
    .cpu_rdat    (cpu_rdat),
    .cpu_busy    (cpu_busy),
    .mcu_req     (mcu_req),
    .mcu_addr    (mcu_addr),
    .mcu_we      (mcu_we),
    .mcu_wdat    (mcu_wdat),
`ifdef PSRAM_MCU_AUTOINC_EN
    .mcu_addr_ld (mcu_addr_ld),
`endif
    .mcu_rdat    (mcu_rdat),
    .mcu_ack     (mcu_ack),
    .mem_addr    (mem_addr),
    .mem_ce      (mem_ce),
    .mem_oe      (mem_oe),
    .mem_we      (mem_we),
    .mem_dati    (mem_dati),
    .mem_dato    (mem_dato)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdat = '0;
    mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_wdat = '0; mcu_addr_ld = 0;
    mem_dato = '0;
    #2;
    total++; if ({mem_ce, mem_we, mem_oe} !== 3'b001) begin bad++; $display("FAIL rst_strobes got=%b exp=001", {mem_ce, mem_we, mem_oe}); end
    total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if (mem_dati !== 8'h0) begin bad++; $display("FAIL rst_dati got=%h exp=0", mem_dati); end
    total++; if (cpu_rdat !== 8'h0 || mcu_rdat !== 8'h0) begin bad++; $display("FAIL rst_rdat got=%h/%h exp=0/0", cpu_rdat, mcu_rdat); end
    total++; if (mcu_ack !== 1'b0 || cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_ack_busy got=%b%b exp=00", mcu_ack, cpu_busy); end
    tick; tick;
    rst = 1'b0;
    tick; tick;
  endtask

  task automatic test_cpu_read;
    logic exp_ce;
    mem_dato = 8'hA5;
    cpu_addr = 24'h000123; cpu_we = 0; cpu_req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      exp_ce = (k >= 2 && k <= 5);
      total++; if (mem_ce !== exp_ce) begin bad++; $display("FAIL cpu_rd_ce k=%0d got=%b exp=%b", k, mem_ce, exp_ce); end
      if (exp_ce) begin
        total++; if (mem_addr !== 24'h000123 || mem_oe !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL cpu_rd_bus k=%0d addr=%h oe=%b we=%b exp 000123/1/0", k, mem_addr, mem_oe, mem_we); end
      end
      if (k == 5) begin
        total++; if (cpu_rdat !== 8'h00) begin bad++; $display("FAIL cpu_rd_early got=%h exp=00", cpu_rdat); end
      end
      total++; if (cpu_busy !== (k <= 5)) begin bad++; $display("FAIL cpu_rd_busy k=%0d got=%b exp=%b", k, cpu_busy, (k <= 5)); end
    end
    total++; if (cpu_rdat !== 8'hA5) begin bad++; $display("FAIL cpu_rd_data got=%h exp=a5", cpu_rdat); end
    cpu_req = 0;
    tick; tick; tick;
  endtask

  task automatic test_mcu_write;
    int acks = 0;
    logic exp_ce;
    mcu_addr = 24'h7FFFFF; mcu_wdat = 8'h3C; mcu_we = 1; mcu_req = 1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      exp_ce = (k <= 4);
      total++; if (mem_ce !== exp_ce) begin bad++; $display("FAIL mcu_wr_ce k=%0d got=%b exp=%b", k, mem_ce, exp_ce); end
      if (exp_ce) begin
        total++; if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_dati !== 8'h3C || mem_addr !== 24'h7FFFFF) begin bad++; $display("FAIL mcu_wr_bus k=%0d we=%b oe=%b dati=%h addr=%h", k, mem_we, mem_oe, mem_dati, mem_addr); end
      end
      total++; if (mcu_ack !== (k == 5)) begin bad++; $display("FAIL mcu_wr_ack k=%0d got=%b exp=%b", k, mcu_ack, (k == 5)); end
      if (mcu_ack) begin acks++; mcu_req = 0; end
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL mcu_wr_ack_count got=%0d exp=1", acks); end
    mcu_req = 0; mcu_we = 0;
    tick; tick;
  endtask

  task automatic test_collision;
    logic exp_ce;
    mem_dato = 8'h5A;
    cpu_addr = 24'h000010; cpu_we = 0; cpu_req = 1;
    tick;
    mcu_addr = 24'h000020; mcu_we = 0; mcu_req = 1;
    for (int k = 1; k <= 13; k++) begin
      tick;
      exp_ce = (k <= 4) || (k >= 7 && k <= 10);
      total++; if (mem_ce !== exp_ce) begin bad++; $display("FAIL coll_ce k=%0d got=%b exp=%b", k, mem_ce, exp_ce); end
      if (k == 1) begin
        total++; if (mem_addr !== 24'h000010) begin bad++; $display("FAIL coll_cpu_first got=%h exp=000010", mem_addr); end
      end
      if (k == 7) begin
        total++; if (mem_addr !== 24'h000020) begin bad++; $display("FAIL coll_mcu_second got=%h exp=000020", mem_addr); end
      end
      if (k == 5) begin
        total++; if (cpu_rdat !== 8'h5A) begin bad++; $display("FAIL coll_cpu_rdat got=%h exp=5a", cpu_rdat); end
      end
      total++; if (mcu_ack !== (k == 11)) begin bad++; $display("FAIL coll_ack k=%0d got=%b exp=%b", k, mcu_ack, (k == 11)); end
      if (mcu_ack) begin
        total++; if (mcu_rdat !== 8'h5A) begin bad++; $display("FAIL coll_mcu_rdat got=%h exp=5a", mcu_rdat); end
        mcu_req = 0;
      end
    end
    mcu_req = 0; cpu_req = 0;
    tick; tick;
  endtask

  task automatic test_cpu_during_mcu;
    logic exp_ce;
    mem_dato = 8'hC3;
    mcu_addr = 24'h000040; mcu_wdat = 8'h77; mcu_we = 1; mcu_req = 1;
    for (int k = 1; k <= 11; k++) begin
      tick;
      if (k == 2) begin cpu_addr = 24'h000050; cpu_we = 0; cpu_req = 1; end
      exp_ce = (k <= 4) || (k >= 7 && k <= 10);
      total++; if (mem_ce !== exp_ce) begin bad++; $display("FAIL cdm_ce k=%0d got=%b exp=%b", k, mem_ce, exp_ce); end
      if (k <= 4) begin
        total++; if (mem_addr !== 24'h000040 || mem_we !== 1'b1) begin bad++; $display("FAIL cdm_mcu_bus k=%0d addr=%h we=%b", k, mem_addr, mem_we); end
      end
      if (k >= 7 && k <= 10) begin
        total++; if (mem_addr !== 24'h000050 || mem_oe !== 1'b1) begin bad++; $display("FAIL cdm_cpu_bus k=%0d addr=%h oe=%b", k, mem_addr, mem_oe); end
      end
      if (k >= 3 && k <= 10) begin
        total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL cdm_busy k=%0d got=%b exp=1", k, cpu_busy); end
      end
      total++; if (mcu_ack !== (k == 5)) begin bad++; $display("FAIL cdm_ack k=%0d got=%b exp=%b", k, mcu_ack, (k == 5)); end
      if (mcu_ack) mcu_req = 0;
    end
    total++; if (cpu_rdat !== 8'hC3 || cpu_busy !== 1'b0) begin bad++; $display("FAIL cdm_cpu_done rdat=%h busy=%b exp c3/0", cpu_rdat, cpu_busy); end
    mcu_req = 0; mcu_we = 0; cpu_req = 0;
    tick; tick;
  endtask

  task automatic test_mcu_drop;
    int acks = 0;
    mem_dato = 8'h99;
    mcu_addr = 24'h000066; mcu_we = 0; mcu_req = 1;
    tick; tick;
    mcu_req = 0;
    for (int k = 3; k <= 8; k++) begin
      tick;
      if (mcu_ack) acks++;
      total++; if (mem_ce !== (k <= 4)) begin bad++; $display("FAIL drop_ce k=%0d got=%b exp=%b", k, mem_ce, (k <= 4)); end
    end
    total++; if (acks !== 0 || mcu_rdat === 8'h99) begin bad++; $display("FAIL drop_no_ack acks=%0d rdat=%h exp 0 and not 99", acks, mcu_rdat); end
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    mcu_addr = 24'h000055; mcu_wdat = 8'h11; mcu_we = 1; mcu_req = 1;
    tick; tick;
    total++; if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL rmid_pre ce=%b we=%b exp 1/1", mem_ce, mem_we); end
    rst = 1'b1;
    #1;
    total++; if ({mem_ce, mem_we, mem_oe} !== 3'b001) begin bad++; $display("FAIL rmid_force got=%b exp=001", {mem_ce, mem_we, mem_oe}); end
    tick;
    mcu_req = 0; mcu_we = 0;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (mcu_ack) acks++;
      total++; if (mem_ce !== 1'b0 || cpu_busy !== 1'b0) begin bad++; $display("FAIL rmid_idle k=%0d ce=%b busy=%b exp 0/0", k, mem_ce, cpu_busy); end
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL rmid_ack got=%0d exp=0", acks); end
  endtask

`ifdef PSRAM_MCU_AUTOINC_EN
  task automatic test_autoinc;
    logic [23:0] seen [3];
    logic [23:0] exp_a [3];
    int n = 0;
    int acks = 0;
    logic ce_prev = 1'b0;
    exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000;
    mcu_addr = 24'hFFFFFE; mcu_we = 0; mcu_req = 1;
    for (int k = 0; k < 40 && acks < 3; k++) begin
      tick;
      if (mem_ce && !ce_prev && n < 3) begin seen[n] = mem_addr; n++; end
      ce_prev = mem_ce;
      // Address input changes mid-burst must be ignored by the pointer.
      mcu_addr = 24'h123456;
      if (mcu_ack) acks++;
      if (acks == 3) mcu_req = 0;
    end
    mcu_req = 0;
    total++; if (acks !== 3 || n !== 3) begin bad++; $display("FAIL ainc_count acks=%0d starts=%0d exp 3/3", acks, n); end
    for (int i = 0; i < n; i++) begin
      total++; if (seen[i] !== exp_a[i]) begin bad++; $display("FAIL ainc_addr%0d got=%h exp=%h", i, seen[i], exp_a[i]); end
    end
    tick; tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_cpu_read;
    test_mcu_write;
    test_collision;
    test_cpu_during_mcu;
    test_mcu_drop;
`ifdef PSRAM_MCU_AUTOINC_EN
    test_autoinc;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
